// File: rtl/sort_column.sv
// rtl/sort_column.sv - 7-input odd-even transposition sorting pipeline, one round per stage.
// Optional SORT_COLUMN_VALID_EN adds in_valid/out_valid tracked alongside the data stages.
module sort_column #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6
`ifdef SORT_COLUMN_VALID_EN
  ,
  input  logic             in_valid,
  output logic             out_valid
`endif
);

  typedef logic [6:0][WIDTH-1:0] col_t;

  col_t in_col;
  col_t stage_q [1:7];
  col_t stage_d [1:7];

  assign in_col = {in6, in5, in4, in3, in2, in1, in0};

  // Odd rounds pair (0,1),(2,3),(4,5); even rounds pair (1,2),(3,4),(5,6).
  // Pairs are disjoint, so swapping in place is safe.
  function automatic col_t round_cx(input col_t v, input logic odd_round);
    col_t             r;
    logic [WIDTH-1:0] t;
    r = v;
    for (int j = 0; j < 6; j++) begin
      if ((((j % 2) == 0) == odd_round) && (r[j] > r[j+1])) begin
        t      = r[j];
        r[j]   = r[j+1];
        r[j+1] = t;
      end
    end
    return r;
  endfunction

  always_comb begin
    stage_d[1] = round_cx(in_col, 1'b1);
    for (int k = 2; k <= 7; k++) begin
      stage_d[k] = round_cx(stage_q[k-1], (k % 2) == 1);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k <= 7; k++) begin
      if (rst) begin
        stage_q[k] <= '0;
      end else begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out0 = stage_q[7][0];
  assign out1 = stage_q[7][1];
  assign out2 = stage_q[7][2];
  assign out3 = stage_q[7][3];
  assign out4 = stage_q[7][4];
  assign out5 = stage_q[7][5];
  assign out6 = stage_q[7][6];

`ifdef SORT_COLUMN_VALID_EN
  logic [6:0] valid_q;
  logic [6:0] valid_d;

  always_comb begin
    valid_d = {valid_q[5:0], in_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q[6];
`endif

endmodule

// File: tb/tb_sort_column.sv
// tb/tb_sort_column.sv - directed and random checks of sort_column against a history-based sort model.
module tb_sort_column;

  typedef logic [55:0] col_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in0, in1, in2, in3, in4, in5, in6;
  logic [7:0] out0, out1, out2, out3, out4, out5, out6;
  col_t       dut_col;

  int total = 0;
  int bad   = 0;

  col_t hist_v[$];
  bit   hist_r[$];

  always #5 clk = ~clk;

  sort_column #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .in5 (in5),
    .in6 (in6),
    .out0(out0),
    .out1(out1),
    .out2(out2),
    .out3(out3),
    .out4(out4),
    .out5(out5),
    .out6(out6)
  );

  assign dut_col = {out6, out5, out4, out3, out2, out1, out0};

  function automatic col_t mk(int a0, int a1, int a2, int a3, int a4, int a5, int a6);
    col_t c;
    c = {a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    return c;
  endfunction

  function automatic col_t sorted(col_t v);
    int   a[7];
    int   t;
    col_t r;
    for (int i = 0; i < 7; i++) a[i] = int'(v[8*i +: 8]);
    for (int i = 1; i < 7; i++) begin
      t = a[i];
      for (int j = i - 1; j >= 0; j--) begin
        if (a[j] > t) begin
          a[j+1] = a[j];
          a[j]   = t;
        end
      end
    end
    r = mk(a[0], a[1], a[2], a[3], a[4], a[5], a[6]);
    return r;
  endfunction

  // Output after edge n: zero if any reset landed in edges n-6..n, else the sorted vector from edge n-6.
  function automatic col_t model();
    int n;
    int lo;
    n  = hist_v.size() - 1;
    lo = (n < 6) ? 0 : n - 6;
    for (int i = lo; i <= n; i++) begin
      if (hist_r[i]) return '0;
    end
    if (n < 6) return '0;
    return sorted(hist_v[n-6]);
  endfunction

  task automatic chk(string tag, col_t exp);
    total++;
    assert (dut_col === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, dut_col, exp);
    end
  endtask

  task automatic step(col_t v, bit r);
    {in6, in5, in4, in3, in2, in1, in0} = v;
    rst = r;
    @(posedge clk);
    hist_v.push_back(v);
    hist_r.push_back(r);
    @(negedge clk);
    chk("model", model());
  endtask

  function automatic col_t rand_col();
    col_t c;
    int   sel;
    for (int i = 0; i < 7; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       c[8*i +: 8] = 8'd0;
        1:       c[8*i +: 8] = 8'd255;
        2:       c[8*i +: 8] = 8'($urandom_range(0, 3));
        default: c[8*i +: 8] = 8'($urandom);
      endcase
    end
    return c;
  endfunction

  initial begin
    // 1: reset hold, then release with inputs held
    for (int i = 0; i < 3; i++) step(mk(0, 1, 2, 3, 4, 5, 6), 1'b1);
    chk("reset_zero", '0);
    for (int i = 0; i < 6; i++) step(mk(0, 1, 2, 3, 4, 5, 6), 1'b0);
    chk("fill_zero", '0);
    step(mk(0, 1, 2, 3, 4, 5, 6), 1'b0);
    chk("first_out", mk(0, 1, 2, 3, 4, 5, 6));

    // 2: reversed vector for one cycle
    step(mk(6, 5, 4, 3, 2, 1, 0), 1'b0);
    for (int i = 0; i < 6; i++) step(mk(9, 9, 9, 9, 9, 9, 9), 1'b0);
    chk("reverse", mk(0, 1, 2, 3, 4, 5, 6));

    // 3: extremes with duplicates, then all equal
    step(mk(255, 0, 128, 7, 7, 1, 254), 1'b0);
    step(mk(42, 42, 42, 42, 42, 42, 42), 1'b0);
    for (int i = 0; i < 5; i++) step(mk(3, 1, 2, 0, 6, 5, 4), 1'b0);
    chk("extremes", mk(0, 1, 7, 7, 128, 254, 255));
    step(mk(3, 1, 2, 0, 6, 5, 4), 1'b0);
    chk("all_equal", mk(42, 42, 42, 42, 42, 42, 42));

    // 4: back-to-back random vectors
    for (int i = 0; i < 1000; i++) step(rand_col(), 1'b0);

    // 5: single-cycle reset mid-stream
    step(rand_col(), 1'b1);
    chk("mid_reset", '0);
    for (int i = 0; i < 6; i++) step(rand_col(), 1'b0);
    chk("mid_reset_flush", '0);
    for (int i = 0; i < 20; i++) step(rand_col(), 1'b0);
    chk("resume", sorted(hist_v[hist_v.size() - 7]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
